// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and received-bit counter for the UART receiver.
module uart_rx_edge_bit_counter #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         bit_clear,
  input  logic                         bit_inc,
  input  logic [PRESCALE_W-1:0]        prescale,
  output logic [PRESCALE_W-1:0]        edge_counter,
  output logic                         bit_end,
  output logic [$clog2(DATA_W+1)-1:0]  bit_count
);

  logic [PRESCALE_W-1:0] last_edge;

  assign last_edge = prescale - PRESCALE_W'(1);
  assign bit_end   = enable && (edge_counter == last_edge);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_counter <= '0;
    end else if (!enable) begin
      edge_counter <= '0;
    end else if (edge_counter == last_edge) begin
      edge_counter <= '0;
    end else begin
      edge_counter <= edge_counter + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_count <= '0;
    end else if (bit_clear) begin
      bit_count <= '0;
    end else if (bit_inc && bit_end) begin
      bit_count <= bit_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive frame sequencer: start detect, LSB-first deserialisation,
// optional parity check, stop check and registered result pulses.
module uart_rx_controller
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  sampled_bit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [PRESCALE_W-1:0] edge_counter,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  rx_state_t             state;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  parity_enable_q;
  logic                  parity_type_q;
  logic                  frame_bad;
  logic [DATA_W-1:0]     shift_q;
  logic                  start_detect;
  logic                  counter_enable;
  logic                  bit_end;
  logic [CNT_W-1:0]      bit_count;
  logic                  last_bit;
  logic                  expected_parity;

  assign start_detect    = (state == IDLE) && !rx_in;
  // The detect cycle counts as edge 0, so the counter runs from that edge on.
  assign counter_enable  = (state != IDLE) || start_detect;
  assign busy            = (state != IDLE);
  assign last_bit        = (bit_count == CNT_W'(DATA_W - 1));
  assign expected_parity = (parity_type_q == PARITY_ODD) ? ~^shift_q : ^shift_q;

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .DATA_W     (DATA_W)
  ) u_edge_bit_counter (
    .clock        (clock),
    .reset        (reset),
    .enable       (counter_enable),
    .bit_clear    (state == START),
    .bit_inc      (state == DATA),
    .prescale     (prescale_q),
    .edge_counter (edge_counter),
    .bit_end      (bit_end),
    .bit_count    (bit_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      prescale_q      <= PRESCALE_W'(PRESCALE_8);
      parity_enable_q <= 1'b0;
      parity_type_q   <= PARITY_EVEN;
      frame_bad       <= 1'b0;
      shift_q         <= '0;
      data_out        <= '0;
      data_valid      <= 1'b0;
      parity_error    <= 1'b0;
      stop_error      <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_detect) begin
            state           <= START;
            prescale_q      <= prescale;
            parity_enable_q <= parity_enable;
            parity_type_q   <= parity_type;
            frame_bad       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= sampled_bit ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= {sampled_bit, shift_q[DATA_W-1:1]};
            if (last_bit) begin
              state <= parity_enable_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            if (sampled_bit != expected_parity) begin
              parity_error <= 1'b1;
              frame_bad    <= 1'b1;
            end
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!sampled_bit) begin
              stop_error <= 1'b1;
            end else if (!frame_bad) begin
              data_out   <= shift_q;
              data_valid <= 1'b1;
            end
            frame_bad <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller with a behavioural majority-vote sampler and frame-level reference model.
module tb_uart_rx_controller;

  localparam int PW = 6;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx_in;
  logic          sampled_bit;
  logic [PW-1:0] prescale;
  logic          parity_enable;
  logic          parity_type;
  logic [PW-1:0] edge_counter;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_error;
  logic          stop_error;
  logic          busy;

  uart_rx_controller #(.PRESCALE_W(PW), .DATA_W(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_in         (rx_in),
    .sampled_bit   (sampled_bit),
    .prescale      (prescale),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .edge_counter  (edge_counter),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .stop_error    (stop_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // kind: 0 = data_valid, 1 = parity_error, 2 = stop_error; edge_n = deciding clock edge
  typedef struct packed {
    int          kind;
    int          edge_n;
    logic [7:0]  d;
  } ev_t;

  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            frame_p = 8;
  ev_t           got_q[$];
  ev_t           exp_q[$];
  logic [7:0]    exp_data = '0;
  logic          s0, s1;

  always @(posedge clock) cyc <= cyc + 1;

  // Sampler: three samples around mid-bit, voted result registered on the last one.
  always @(posedge clock) begin
    if (reset) begin
      sampled_bit <= 1'b1;
    end else begin
      if (int'(edge_counter) == frame_p / 2 - 2) s0 <= rx_in;
      if (int'(edge_counter) == frame_p / 2 - 1) s1 <= rx_in;
      if (int'(edge_counter) == frame_p / 2)
        sampled_bit <= (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid)   got_q.push_back('{kind: 0, edge_n: cyc, d: data_out});
      if (parity_error) got_q.push_back('{kind: 1, edge_n: cyc, d: 8'h00});
      if (stop_error)   got_q.push_back('{kind: 2, edge_n: cyc, d: 8'h00});
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reference outcome of one frame whose detect edge is t.
  task automatic model_frame(input int t, input int p, input logic [7:0] b, input logic pe,
                             input logic pt, input logic par, input logic stop);
    int  ones;
    int  stop_edge;
    bit  par_ok;
    ones      = $countones(b) + int'(par);
    par_ok    = !pe || ((ones % 2) == int'(pt));
    stop_edge = t + (10 + int'(pe)) * p - 1;
    if (!par_ok) exp_q.push_back('{kind: 1, edge_n: stop_edge - p, d: 8'h00});
    if (!stop) begin
      exp_q.push_back('{kind: 2, edge_n: stop_edge, d: 8'h00});
    end else if (par_ok) begin
      exp_q.push_back('{kind: 0, edge_n: stop_edge, d: b});
      exp_data = b;
    end
  endtask

  function automatic logic good_parity(input logic [7:0] b, input logic pt);
    return logic'(($countones(b) + int'(pt)) % 2);
  endfunction

  // Drives one frame on rx_in; must be entered #1 after a rising edge.
  task automatic send_frame(input int p, input logic [7:0] b, input logic pe, input logic pt,
                            input logic par, input logic stop, input bit predict, output int t);
    frame_p       = p;
    prescale      = PW'(p);
    parity_enable = pe;
    parity_type   = pt;
    rx_in         = 1'b0;
    t             = cyc + 1;
    wait_cycles(p);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      wait_cycles(p);
    end
    if (pe) begin
      rx_in = par;
      wait_cycles(p);
    end
    rx_in = stop;
    wait_cycles(p);
    rx_in = 1'b1;
    if (predict) model_frame(t, p, b, pe, pt, par, stop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    prescale = PW'(8);
    parity_enable = 1'b0;
    parity_type = 1'b0;
    wait_cycles(3);
    vectors++;
    if ({data_out, data_valid, parity_error, stop_error, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b/%b, expected all zero",
               data_out, data_valid, parity_error, stop_error, busy);
    end
    vectors++;
    if (edge_counter !== '0) begin
      miscompares++;
      $display("FAIL reset_edge_counter: got %0d, expected 0", edge_counter);
    end
    reset = 1'b0;
    wait_cycles(3);
    vectors++;
    if (busy !== 1'b0 || edge_counter !== '0) begin
      miscompares++;
      $display("FAIL idle_hold: got busy %b edge %0d, expected 0 and 0", busy, edge_counter);
    end
  endtask

  task automatic test_basic();
    int t;
    got_q.delete(); exp_q.delete();
    fork
      send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t);
      begin
        wait_cycles(1);
        vectors++;
        if (busy !== 1'b1 || edge_counter !== PW'(1)) begin
          miscompares++;
          $display("FAIL basic_detect: got busy %b edge %0d, expected 1 and 1", busy, edge_counter);
        end
      end
    join
    wait_cycles(3);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL basic events: got %0d, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL basic event%0d: got kind %0d edge %0d data %h, expected kind %0d edge %0d data %h",
                 i, got_q[i].kind, got_q[i].edge_n, got_q[i].d, exp_q[i].kind, exp_q[i].edge_n, exp_q[i].d);
      end
    end
    vectors++;
    if (data_out !== exp_data || exp_q.size() != 1 || exp_q[0].edge_n != t + 79) begin
      miscompares++;
      $display("FAIL basic data_out: got %h, expected %h at edge T+79", data_out, exp_data);
    end
  endtask

  task automatic test_parity_odd();
    int t;
    got_q.delete(); exp_q.delete();
    send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, t);
    send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, t);
    send_frame(16, 8'h96, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, t);
    wait_cycles(3);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL parity events: got %0d, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL parity event%0d: got kind %0d edge %0d data %h, expected kind %0d edge %0d data %h",
                 i, got_q[i].kind, got_q[i].edge_n, got_q[i].d, exp_q[i].kind, exp_q[i].edge_n, exp_q[i].d);
      end
    end
    vectors++;
    if (data_out !== 8'h3C) begin
      miscompares++;
      $display("FAIL parity data_out: got %h, expected 3c", data_out);
    end
  endtask

  task automatic test_framing();
    int t;
    got_q.delete(); exp_q.delete();
    send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
    vectors++;
    if (data_out !== 8'h3C) begin
      miscompares++;
      $display("FAIL framing data_out_kept: got %h, expected 3c", data_out);
    end
    wait_cycles(1);
    send_frame(8, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t);
    wait_cycles(3);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL framing events: got %0d, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL framing event%0d: got kind %0d edge %0d data %h, expected kind %0d edge %0d data %h",
                 i, got_q[i].kind, got_q[i].edge_n, got_q[i].d, exp_q[i].kind, exp_q[i].edge_n, exp_q[i].d);
      end
    end
  endtask

  task automatic test_start_glitch();
    int t;
    got_q.delete(); exp_q.delete();
    frame_p = 8;
    prescale = PW'(8);
    parity_enable = 1'b0;
    rx_in = 1'b0;
    t = cyc + 1;
    wait_cycles(2);
    rx_in = 1'b1;
    wait_cycles(5);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch busy_at_T+6: got %b, expected 1", busy);
    end
    wait_cycles(1);
    vectors++;
    if (busy !== 1'b0 || edge_counter !== '0) begin
      miscompares++;
      $display("FAIL glitch idle_at_T+7 (T=%0d): got busy %b edge %0d, expected 0 and 0", t, busy, edge_counter);
    end
    wait_cycles(2);
    send_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t);
    wait_cycles(3);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL glitch events: got %0d, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL glitch event%0d: got kind %0d edge %0d data %h, expected kind %0d edge %0d data %h",
                 i, got_q[i].kind, got_q[i].edge_n, got_q[i].d, exp_q[i].kind, exp_q[i].edge_n, exp_q[i].d);
      end
    end
  endtask

  task automatic test_config_change();
    int t;
    got_q.delete(); exp_q.delete();
    fork
      send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t);
      begin
        wait_cycles(30);
        prescale = PW'(16);
        parity_enable = 1'b1;
        parity_type = 1'b1;
      end
    join
    wait_cycles(3);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL cfgchg events: got %0d, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL cfgchg event%0d: got kind %0d edge %0d data %h, expected kind %0d edge %0d data %h",
                 i, got_q[i].kind, got_q[i].edge_n, got_q[i].d, exp_q[i].kind, exp_q[i].edge_n, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    got_q.delete(); exp_q.delete();
    fork
      send_frame(8, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, t);
      begin
        wait_cycles(9 * 8 + 3);
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL rstmid busy_before: got %b, expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({data_out, data_valid, parity_error, stop_error, busy, edge_counter} !== '0) begin
          miscompares++;
          $display("FAIL rstmid async_clear: got data %h valid %b perr %b serr %b busy %b edge %0d, expected all zero",
                   data_out, data_valid, parity_error, stop_error, busy, edge_counter);
        end
      end
    join
    wait_cycles(1);
    reset = 1'b0;
    exp_data = '0;
    wait_cycles(3);
    vectors++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid no_pulses: got %0d events busy %b, expected 0 events busy 0", got_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    got_q.delete(); exp_q.delete();
    send_frame(32, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t1);
    send_frame(32, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t2);
    wait_cycles(3);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b events: got %0d, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b event%0d: got kind %0d edge %0d data %h, expected kind %0d edge %0d data %h",
                 i, got_q[i].kind, got_q[i].edge_n, got_q[i].d, exp_q[i].kind, exp_q[i].edge_n, exp_q[i].d);
      end
    end
    vectors++;
    if (got_q.size() != 2 || (got_q.size() == 2 && got_q[1].edge_n - got_q[0].edge_n != 320)) begin
      miscompares++;
      $display("FAIL b2b spacing: got %0d pulses, expected 2 pulses 320 cycles apart", got_q.size());
    end
  endtask

  task automatic test_random();
    int         t;
    int         ps[3];
    int         p;
    logic [7:0] b;
    logic       pe, pt, par, stop;
    ps = '{8, 16, 32};
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 10; n++) begin
      p    = ps[$urandom_range(2)];
      b    = 8'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      par  = good_parity(b, pt) ^ ($urandom_range(3) == 0);
      stop = ($urandom_range(7) != 0);
      send_frame(p, b, pe, pt, par, stop, 1'b1, t);
      wait_cycles($urandom_range(3));
    end
    wait_cycles(3);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random events: got %0d, expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random event%0d: got kind %0d edge %0d data %h, expected kind %0d edge %0d data %h",
                 i, got_q[i].kind, got_q[i].edge_n, got_q[i].d, exp_q[i].kind, exp_q[i].edge_n, exp_q[i].d);
      end
    end
    vectors++;
    if (data_out !== exp_data) begin
      miscompares++;
      $display("FAIL random data_out: got %h, expected %h", data_out, exp_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_odd();
    test_framing();
    test_start_glitch();
    test_config_change();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- Frame-sequencing FSM for the UART receiver. It detects the start bit and drives the per-bit oversampling edge counter consumed by the majority-vote data sampler.
- Consumes the sampler's voted bit, deserializes 8 data bits LSB-first, checks optional parity and the stop bit, and emits one data_valid pulse per good frame.
- Sits between the raw rx line and the Rx top-level output registers.

Parameters:
- PRESCALE_W, 6, width of prescale and edge_counter.
- DATA_W, 8, data bits per frame.

Ports:
- clock  in  1  system clock, prescale times the baud rate.
- reset  in  1  reset, asynchronous, active-high. The sampler's active-low reset is driven by the inverted signal at integration.
- rx_in  in  1  synchronized serial line, idle high.
- sampled_bit  in  1  majority-voted bit from the data sampler.
- prescale  in  PRESCALE_W  oversampling ratio. Legal values are 8, 16 and 32.
- parity_enable  in  1  1 = frame carries a parity bit.
- parity_type  in  1  0 = even, 1 = odd.
- edge_counter  out  PRESCALE_W  oversampling edge index within the current bit, routed to the sampler.
- data_out  out  DATA_W  last good received byte.
- data_valid  out  1  one-cycle pulse when data_out updates.
- parity_error  out  1  one-cycle pulse on parity mismatch.
- stop_error  out  1  one-cycle pulse on stop bit sampled low.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset: state = IDLE. edge_counter, bit_count, shift register, data_out, data_valid, parity_error and stop_error all clear to 0. Reset asserted mid-frame aborts the frame immediately with no pulses.
- Config latch: prescale, parity_enable and parity_type are latched on the start-detect edge. Changes during a frame are ignored until the next frame.
- Edge counter:
  - Held at 0 in IDLE.
  - Otherwise increments each clock.
  - Wraps from latched_prescale-1 to 0. This wrap edge is the "bit end".
- Sampler latency: sampler samples are taken at edges p/2-2, p/2-1 and p/2, and are registered. sampled_bit is valid from edge p/2+1, so the controller reads sampled_bit only at bit end.
- States and transitions:
  - IDLE: rx_in==0 at a clock edge → START, edge_counter <= 1 (the detect cycle is edge 0).
  - START, at bit end: sampled_bit==0 → DATA with bit_count=0. sampled_bit==1 → IDLE (glitch; no pulses, no output change).
  - DATA, at each bit end: shift sampled_bit into the MSB of the shift register (right shift, LSB-first line order) and increment bit_count. After bit DATA_W-1 → PARITY if parity_enable, else → STOP.
  - PARITY, at bit end:
    - Expected parity = ^shift for even, ~^shift for odd.
    - On mismatch, pulse parity_error in the next cycle and set an internal frame_bad flag.
    - → STOP.
  - STOP, at bit end:
    - sampled_bit==0: pulse stop_error.
    - Otherwise, if frame_bad==0: data_out <= shift and pulse data_valid.
    - In all cases → IDLE and clear frame_bad.
- Output timing: all pulses are registered, high exactly one cycle, in the cycle following the deciding edge. Error frames never update data_out.
- Back-to-back frames: IDLE is re-entered on the stop bit-end edge. A low rx_in on the very next edge starts a new frame, so there are no dead cycles beyond that one edge.
- rx_in: ignored outside IDLE. Line activity mid-frame affects the frame only through sampled_bit.
- Frame latency: with detect edge T and p = prescale, the stop bit ends at edge T + (10 + parity_enable)·p − 1.

Decomposition:
- Package uart_rx_pkg:
  - State enum {IDLE, START, DATA, PARITY, STOP}, 3-bit encoding.
  - Constants PARITY_EVEN=0 and PARITY_ODD=1.
  - Legal prescale constants 8, 16 and 32.
- One sub-module, uart_rx_edge_bit_counter:
  - Implements the edge counter and bit counter.
  - Inputs: enable, latched prescale.
  - Outputs: edge_counter, bit_end, bit_count.
- The FSM, shift register, parity check and output registers stay in uart_rx_controller.

Test Plan:
- Basic frame: p=8, no parity, frame 0xA5 driven with the sampler model → data_out=0xA5. data_valid is high for exactly one cycle after edge T+79. No error pulses.
- Odd parity: p=16, parity_enable=1, odd parity, byte 0x3C, parity bit 1 → data_valid, data_out=0x3C. Repeat with parity bit 0 → parity_error pulse, no data_valid, data_out unchanged.
- Framing error: p=8, byte 0xFF, stop bit driven 0 → stop_error pulse at T+79, no data_valid. The next frame, 0x12, is received correctly.
- Start glitch: rx_in low for 2 cycles at p=8 → returns to IDLE after edge T+7, busy drops, no pulses. Then a valid 0x81 frame is received.
- Mid-frame config change and reset:
  - Change prescale from 8 to 16 during the DATA state → frame still decoded at 8, byte 0x5A is correct.
  - Assert reset during the PARITY state → all outputs are 0 and state is IDLE asynchronously, with no pulses.
- Back-to-back frames: 0x01 then 0xFE with no idle gap between the stop bit and the next start bit, p=32 → two data_valid pulses exactly 320 cycles apart.
